// File: rtl/tsc_fault_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tsc_fault_monitor                                              |
// | Desc    : Registers the corrected operand pair and escalates TSC two-rail|
// |           code errors OK -> SUSPECT -> FAULT (sticky spare select).      |
// |           Optional first-error operand log: define TSC_FAULT_LOG_EN.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tsc_fault_monitor #(
  parameter int DATA_W      = 16,
  parameter int ERR_THRESH  = 3,
  parameter int RECOVER_CNT = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              f,
  input  logic              g,
  input  logic [DATA_W-1:0] final_x,
  input  logic [DATA_W-1:0] final_y,
  input  logic              fault_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic              reconfig_sel,
  output logic [1:0]        fault_state,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              alarm
`ifdef TSC_FAULT_LOG_EN
  ,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] log_x,
  output logic [DATA_W-1:0] log_y,
  output logic              log_valid
`endif
);

  localparam int C_CW = $clog2(ERR_THRESH + 1);
  localparam int C_GW = $clog2(RECOVER_CNT + 1);
  localparam logic [C_CW-1:0] c_err_thresh  = C_CW'(ERR_THRESH);
  localparam logic [C_GW-1:0] c_recover_cnt = C_GW'(RECOVER_CNT);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [C_CW-1:0]   r_consec, w_consec_nxt, w_consec_inc;
  logic [C_GW-1:0]   r_good, w_good_nxt, w_good_inc;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_alarm;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_x, r_out_y;
  logic              w_err;

  // Two-rail code error: both rails equal on a qualified sample
  assign w_err        = in_valid & ~(f ^ g);
  assign w_consec_inc = r_consec + 1'b1;
  assign w_good_inc   = r_good + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_OK;
      r_consec <= '0;
      r_good   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_consec <= w_consec_nxt;
      r_good   <= w_good_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_consec_nxt = r_consec;
    w_good_nxt   = r_good;
    if (fault_clr) begin
      w_state_nxt  = ST_OK;
      w_consec_nxt = '0;
      w_good_nxt   = '0;
    end else if (in_valid) begin
      case (r_state)
        ST_OK: begin
          if (w_err) begin
            w_consec_nxt = C_CW'(1);
            w_good_nxt   = '0;
            w_state_nxt  = (ERR_THRESH == 1) ? ST_FAULT : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          // A good sample does not reset the consecutive-error count
          if (w_err) begin
            w_good_nxt   = '0;
            w_consec_nxt = w_consec_inc;
            if (w_consec_inc == c_err_thresh) w_state_nxt = ST_FAULT;
          end else if (w_good_inc == c_recover_cnt) begin
            w_state_nxt  = ST_OK;
            w_consec_nxt = '0;
            w_good_nxt   = '0;
          end else begin
            w_good_nxt   = w_good_inc;
          end
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_OK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
      r_alarm   <= 1'b0;
    end else begin
      r_alarm <= (w_state_nxt == ST_FAULT) && (r_state != ST_FAULT);
      if (fault_clr)
        r_err_cnt <= '0;
      else if (w_err && (r_err_cnt != {CNT_W{1'b1}}))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out_x <= final_x;
        r_out_y <= final_y;
      end
    end
  end

`ifdef TSC_FAULT_LOG_EN
  logic [DATA_W-1:0] r_log_x, r_log_y;
  logic              r_log_valid;

  // Only the first error since reset/clear is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_log_x     <= '0;
      r_log_y     <= '0;
      r_log_valid <= 1'b0;
    end else if (fault_clr) begin
      r_log_x     <= '0;
      r_log_y     <= '0;
      r_log_valid <= 1'b0;
    end else if (w_err && !r_log_valid) begin
      r_log_x     <= x0;
      r_log_y     <= y0;
      r_log_valid <= 1'b1;
    end
  end

  assign log_x     = r_log_x;
  assign log_y     = r_log_y;
  assign log_valid = r_log_valid;
`endif

  assign out_valid    = r_out_valid;
  assign out_x        = r_out_x;
  assign out_y        = r_out_y;
  assign reconfig_sel = (r_state == ST_FAULT);
  assign fault_state  = r_state;
  assign err_cnt      = r_err_cnt;
  assign alarm        = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_tsc_fault_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_tsc_fault_monitor                                           |
// | Desc    : Directed self-checking bench for tsc_fault_monitor.            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_tsc_fault_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, f, g, fault_clr;
  logic [15:0] final_x, final_y;
  logic        out_valid, reconfig_sel, alarm;
  logic [15:0] out_x, out_y;
  logic [1:0]  fault_state;
  logic [7:0]  err_cnt;
`ifdef TSC_FAULT_LOG_EN
  logic [15:0] x0, y0, log_x, log_y;
  logic        log_valid;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tsc_fault_monitor #(
    .DATA_W(16), .ERR_THRESH(3), .RECOVER_CNT(4), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .f(f), .g(g),
    .final_x(final_x), .final_y(final_y), .fault_clr(fault_clr),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .reconfig_sel(reconfig_sel), .fault_state(fault_state),
    .err_cnt(err_cnt), .alarm(alarm)
`ifdef TSC_FAULT_LOG_EN
    , .x0(x0), .y0(y0), .log_x(log_x), .log_y(log_y), .log_valid(log_valid)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one sample, clock it in, and settle just after the edge
  task automatic step(input logic v, input logic ff, input logic gg,
                      input logic [15:0] x, input logic clr);
    in_valid  = v;
    f         = ff;
    g         = gg;
    final_x   = x;
    final_y   = ~x;
    fault_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic good(input logic [15:0] x);
    step(1'b1, 1'b1, 1'b0, x, 1'b0);
  endtask

  task automatic bad(input logic [15:0] x);
    step(1'b1, 1'b1, 1'b1, x, 1'b0);
  endtask

  int alarm_seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; f = 1'b0; g = 1'b0; fault_clr = 1'b0;
    final_x = '0; final_y = '0;
`ifdef TSC_FAULT_LOG_EN
    x0 = 16'hAAAA; y0 = 16'h0A0A;
`endif
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_state", fault_state, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_reconfig", reconfig_sel, 0);
    @(negedge clk); rst_n = 1'b1;

    // Clean traffic
    alarm_seen = 0;
    for (int i = 0; i < 10; i++) begin
      good(16'h1234);
      if (alarm) alarm_seen++;
    end
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_x", out_x, 16'h1234);
    chk("t1_out_y", out_y, 16'hEDCB);
    chk("t1_state", fault_state, 0);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_no_alarm", alarm_seen, 0);
    step(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_x_hold", out_x, 16'h1234);
    chk("t1_invalid_err_ignored", err_cnt, 0);

    // Single transient, then recovery after four good samples
    bad(16'h0001);
    chk("t2_suspect", fault_state, 1);
    chk("t2_cnt", err_cnt, 1);
`ifdef TSC_FAULT_LOG_EN
    chk("t2_log_valid", log_valid, 1);
    chk("t2_log_x", log_x, 16'hAAAA);
    x0 = 16'h5555;
`endif
    good(16'h0002); good(16'h0003); good(16'h0004);
    chk("t2_still_suspect", fault_state, 1);
    good(16'h0005);
    chk("t2_recovered", fault_state, 0);
    chk("t2_cnt_kept", err_cnt, 1);

    // Persistent error: three in a row
    bad(16'h0010);
    chk("t3_s1", fault_state, 1);
    bad(16'h0011);
    chk("t3_s2", fault_state, 1);
    chk("t3_no_early_alarm", alarm, 0);
    bad(16'h0012);
    chk("t3_fault", fault_state, 2);
    chk("t3_reconfig", reconfig_sel, 1);
    chk("t3_alarm", alarm, 1);
    chk("t3_cnt", err_cnt, 4);
    good(16'h0013);
    chk("t3_alarm_pulse", alarm, 0);
    chk("t3_sticky", fault_state, 2);
    good(16'h0014); good(16'h0015); good(16'h0016); good(16'h0017);
    chk("t3_sticky_after_goods", fault_state, 2);
    bad(16'h0018);
    chk("t3_cnt_in_fault", err_cnt, 5);
    chk("t3_no_realarm", alarm, 0);
`ifdef TSC_FAULT_LOG_EN
    chk("t3_log_not_overwritten", log_x, 16'hAAAA);
`endif

    // Clear wins over a simultaneous error sample
    step(1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b1);
    chk("t5_state", fault_state, 0);
    chk("t5_cnt", err_cnt, 0);
    chk("t5_reconfig", reconfig_sel, 0);
    chk("t5_out_x", out_x, 16'hBEEF);
    chk("t5_alarm", alarm, 0);
`ifdef TSC_FAULT_LOG_EN
    chk("t5_log_cleared", log_valid, 0);
`endif

    // Good samples in SUSPECT do not reset the consecutive count
    bad(16'h0020);
    chk("t4_s1", fault_state, 1);
    good(16'h0021);
    chk("t4_s2", fault_state, 1);
    bad(16'h0022);
    chk("t4_s3", fault_state, 1);
    bad(16'h0023);
    chk("t4_fault", fault_state, 2);
    chk("t4_alarm", alarm, 1);
    chk("t4_cnt", err_cnt, 3);
`ifdef TSC_FAULT_LOG_EN
    chk("t4_log_x", log_x, 16'h5555);
`endif

    // Saturation of the error counter
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 260; i++) bad(16'h0030);
    chk("t6_saturated", err_cnt, 8'hFF);

    // Asynchronous reset in the middle of an error burst
    bad(16'h0031);
    in_valid = 1'b1; f = 1'b0; g = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_state", fault_state, 0);
    chk("t6_arst_cnt", err_cnt, 0);
    chk("t6_arst_valid", out_valid, 0);
    chk("t6_arst_x", out_x, 0);
    chk("t6_arst_reconfig", reconfig_sel, 0);
    chk("t6_arst_alarm", alarm, 0);
`ifdef TSC_FAULT_LOG_EN
    chk("t6_arst_log", log_valid, 0);
`endif
    @(posedge clk); #1;
    chk("t6_arst_held", err_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    good(16'h4321);
    chk("t6_post_rst_x", out_x, 16'h4321);
    chk("t6_post_rst_state", fault_state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
